cla_pipe_addsub: RTL and testbench
==================================

Name: cla_pipe_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath; the multi-cycle successor to the single 4-bit lookahead cell.
- Operand width is split into STAGES equal slices. Each slice is a two-level lookahead built from BLOCK-bit cells with group propagate/generate.
- The slice carry is registered between stages (skewed pipeline).
- Valid/ready handshake on both sides with full backpressure; one result per cycle at steady state.

Parameters:
- WIDTH, 32, operand/result width in bits.
- BLOCK, 4, bits per lookahead cell.
- STAGES, 2, pipeline stages; WIDTH must be divisible by STAGES*BLOCK (elaboration error otherwise).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in (add only).
- in_sub  in  1  1 = A-B, 0 = A+B+cin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  carry-out of MSB (for sub: 1 = no borrow).

Behaviour:
- Beat accepted when in_valid & in_ready. Result delivered when out_valid & out_ready.
- Operand transform at accept:
  - sub: b_eff = ~in_b, c_eff = 1, in_cin ignored.
  - add: b_eff = in_b, c_eff = in_cin.
- Slice width SW = WIDTH/STAGES. Stage k (0..STAGES-1):
  - computes sum bits [k*SW +: SW] from its registered carry and the slice operands;
  - registers that sum, the slice carry-out, and the still-unprocessed upper operand slices.
  - Earlier sum slices travel forward unchanged.
- Inside a slice: per-cell P = a^b, G = a&b; cell group P_out/G_out; cell carries by lookahead over cells, not by ripple between cells.
- Latency: exactly STAGES cycles from accept to out_valid when not stalled. Throughput: 1 beat/cycle.
- Stall is global: advance = !out_valid | out_ready; in_ready = advance (combinational).
  - When advance = 0, every stage register, including valid bits and out_*, holds.
- Bubbles: a stage's valid bit is cleared when advance and the upstream stage is invalid. Bubbles are squeezed only by advancing, never out of order.
- out_sum/out_cout are stable while out_valid & !out_ready.
- Reset (asynchronous, any time): all stage valid bits, out_valid, out_sum, out_cout go to 0. In-flight beats are discarded and not replayed. in_ready = 1 in the first cycle after reset release.
- Boundaries:
  - All-ones + cin=1: sum 0, cout 1, with carry crossing every slice.
  - Simultaneous accept and deliver in one cycle is legal and keeps the pipeline full.
  - in_valid while in_ready = 0: the beat is not taken; the source must hold it.

Optional Feature:
- Macro CLA_PIPE_FLAGS_EN.
- Defined:
  - adds outputs out_ovf (1 bit, signed overflow = carry into MSB XOR carry out of MSB) and out_zero (1 bit, out_sum == 0);
  - both are registered alongside out_sum, reset to 0, and held under stall.
- Undefined: the ports do not exist; no extra logic.

Decomposition:
- Shared package cla_pkg:
  - typedef for the cell P/G pair;
  - constant default BLOCK = 4;
  - function computing slice width with a divisibility check.
- One sub-module: cla_cell (BLOCK-bit lookahead cell; inputs a, b, cin; outputs sum, P_out, G_out).
- Pipeline control and slice lookahead stay in cla_pipe_addsub.

Test Plan:
- Defaults, add 0x0000FFFF + 0x00000001, cin=0 -> after 2 cycles out_sum=0x00010000, cout=0; carry crosses the slice boundary.
- Add 0xFFFFFFFF + 0x00000000, cin=1 -> out_sum=0x00000000, cout=1; with FLAGS: zero=1, ovf=0.
- Sub 0x00000005 - 0x00000007 -> out_sum=0xFFFFFFFE, cout=0; with FLAGS: ovf=0. Sub 0x80000000 - 1 -> 0x7FFFFFFF, ovf=1.
- 8 back-to-back beats with out_ready=1 -> 8 results on consecutive cycles starting cycle 2, in order. Then out_ready=0 for 3 cycles -> in_ready=0 and out_* held. Release -> no loss, no duplication.
- Two beats in flight, assert rst mid-cycle -> out_valid=0 immediately. After release, no stale result appears; a new beat 3+4 -> 7.
- WIDTH=64, BLOCK=4, STAGES=4: random 10k beats with random in_valid/out_ready -> each result matches a+b+cin or a-b, order preserved, latency 4 when unstalled.

Source files
------------

// File: rtl/cla_pkg.sv
// cla_pkg: shared types and lookahead helpers for the pipelined adder.
// Helpers cover groups of up to CLA_MAXN cells or bits.
package cla_pkg;

    localparam int CLA_BLOCK_DEF = 4;
    localparam int CLA_MAXN      = 32;

    typedef struct packed {
        logic [CLA_MAXN-1:0] p;
        logic [CLA_MAXN-1:0] g;
    } cla_pg_t;

    function automatic int cla_slice_width(
        input int width,
        input int stages,
        input int block
    );
        if (stages < 1 || block < 1) return 0;
        if (width % (stages * block) != 0) return 0;
        return width / stages;
    endfunction

    // Carry into position n as a flat sum of products, no ripple chain.
    function automatic logic cla_carry(
        input cla_pg_t pg,
        input logic    c0,
        input int      n
    );
        logic c;
        logic t;
        c = c0;
        for (int m = 0; m < n; m++) c = c & pg.p[m];
        for (int i = 0; i < n; i++) begin
            t = pg.g[i];
            for (int m = i + 1; m < n; m++) t = t & pg.p[m];
            c = c | t;
        end
        return c;
    endfunction

endpackage

// File: rtl/cla_cell.sv
// cla_cell: BLOCK-bit lookahead cell with group propagate/generate.
module cla_cell
    import cla_pkg::*;
#(
    parameter int BLOCK = CLA_BLOCK_DEF
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             P_out,
    output logic             G_out
);

    cla_pg_t pg;

    always_comb begin
        pg = '0;
        pg.p[BLOCK-1:0] = a ^ b;
        pg.g[BLOCK-1:0] = a & b;
    end

    // Group terms depend on a/b only, so the slice lookahead sees no loop.
    assign P_out = &pg.p[BLOCK-1:0];
    assign G_out = cla_carry(pg, 1'b0, BLOCK);

    always_comb begin
        sum = '0;
        for (int j = 0; j < BLOCK; j++) begin
            sum[j] = pg.p[j] ^ cla_carry(pg, cin, j);
        end
    end

endmodule

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: skewed pipelined lookahead add/sub, one slice per stage.
// Define CLA_PIPE_FLAGS_EN for registered out_ovf/out_zero outputs.
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = CLA_BLOCK_DEF,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
`ifdef CLA_PIPE_FLAGS_EN
    ,
    output logic             out_ovf,
    output logic             out_zero
`endif
);

    localparam int SWC = cla_slice_width(WIDTH, STAGES, BLOCK);
    localparam int SW  = (SWC > 0) ? SWC : BLOCK;
    localparam int NC  = SW / BLOCK;
    localparam int L   = STAGES - 1;

    if (SWC == 0 || BLOCK > CLA_MAXN || NC > CLA_MAXN) begin : g_bad_cfg
        $error("cla_pipe_addsub: WIDTH not divisible by STAGES*BLOCK");
    end

    logic [WIDTH-1:0] st_a [STAGES];
    logic [WIDTH-1:0] st_b [STAGES];
    logic [WIDTH-1:0] st_s [STAGES];
    logic             st_c [STAGES];
    logic             st_v [STAGES];
    logic [WIDTH-1:0] s_d  [STAGES];
    logic             c_d  [STAGES];
    logic [WIDTH-1:0] a_q  [STAGES];
    logic [WIDTH-1:0] b_q  [STAGES];
    logic [WIDTH-1:0] s_q  [STAGES];
    logic             c_q  [STAGES];
    logic             v_q  [STAGES];
    logic             adv;

    assign adv      = !v_q[L] || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW-1:0]    sl_sum;
        logic [NC-1:0]    cp;
        logic [NC-1:0]    cg;
        logic [NC:0]      cc;
        logic [WIDTH-1:0] sum_full;
        cla_pg_t          grp;

        if (k == 0) begin : g_head
            assign st_a[k] = in_a;
            assign st_b[k] = in_sub ? ~in_b : in_b;
            assign st_c[k] = in_sub | in_cin;
            assign st_s[k] = '0;
            assign st_v[k] = in_valid;
        end else begin : g_body
            assign st_a[k] = a_q[k-1];
            assign st_b[k] = b_q[k-1];
            assign st_c[k] = c_q[k-1];
            assign st_s[k] = s_q[k-1];
            assign st_v[k] = v_q[k-1];
        end

        for (genvar j = 0; j < NC; j++) begin : g_cell
            cla_cell #(
                .BLOCK(BLOCK)
            ) u_cell (
                .a    (st_a[k][k*SW + j*BLOCK +: BLOCK]),
                .b    (st_b[k][k*SW + j*BLOCK +: BLOCK]),
                .cin  (cc[j]),
                .sum  (sl_sum[j*BLOCK +: BLOCK]),
                .P_out(cp[j]),
                .G_out(cg[j])
            );
        end

        always_comb begin
            grp = '0;
            grp.p[NC-1:0] = cp;
            grp.g[NC-1:0] = cg;
            cc = '0;
            for (int j = 0; j <= NC; j++) begin
                cc[j] = cla_carry(grp, st_c[k], j);
            end
        end

        always_comb begin
            sum_full = st_s[k];
            sum_full[k*SW +: SW] = sl_sum;
        end

        assign s_d[k] = sum_full;
        assign c_d[k] = cc[NC];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                s_q[k] <= '0;
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= st_v[k];
                if (st_v[k]) begin
                    c_q[k] <= c_d[k];
                    s_q[k] <= s_d[k];
                    a_q[k] <= st_a[k];
                    b_q[k] <= st_b[k];
                end
            end
        end
    end

    assign out_valid = v_q[L];
    assign out_sum   = s_q[L];
    assign out_cout  = c_q[L];

`ifdef CLA_PIPE_FLAGS_EN
    logic ovf_d;
    logic zero_d;
    logic ovf_q;
    logic zero_q;

    // Carry into the MSB is recovered from its sum bit and operands.
    assign ovf_d  = s_d[L][WIDTH-1] ^ st_a[L][WIDTH-1]
                  ^ st_b[L][WIDTH-1] ^ c_d[L];
    assign zero_d = (s_d[L] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv && st_v[L]) begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_ovf  = ovf_q;
    assign out_zero = zero_q;
`endif

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb_cla_pipe_addsub: directed table, burst/stall/reset sequences and a
// randomized scoreboard run; flags checked when CLA_PIPE_FLAGS_EN is set.
module tb_cla_pipe_addsub;

    localparam int W  = 32;
    localparam int ST = 2;
    localparam int NV = 10;
    localparam int NR = 400;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
`ifdef CLA_PIPE_FLAGS_EN
    logic         out_ovf;
    logic         out_zero;
`endif

    cla_pipe_addsub #(
        .WIDTH (W),
        .BLOCK (4),
        .STAGES(ST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout)
`ifdef CLA_PIPE_FLAGS_EN
        ,
        .out_ovf  (out_ovf),
        .out_zero (out_zero)
`endif
    );

    always #5 clk = ~clk;

    int          n_run = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    typedef struct packed {
        res_t        r;
        int unsigned t;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } vec_t;

    vec_t tbl [NV];
    exp_t q[$];
    bit   mon_en = 1'b0;
    bit   lat_chk = 1'b0;
    bit   done;
    int   n_del = 0;
    int unsigned first_del;
    int unsigned last_del;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        n_run++;
        n_fail++;
        $display("FAIL %s: no progress within cycle bound", name);
    endtask

    // Reference: plain wide addition, overflow from operand/result signs.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        logic [W-1:0] be;
        logic [W:0]   t;
        res_t         r;
        be     = sub ? ~b : b;
        t      = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub | cin)};
        r.sum  = t[W-1:0];
        r.cout = t[W];
        r.ovf  = (a[W-1] == be[W-1]) && (r.sum[W-1] != a[W-1]);
        r.zero = (r.sum == '0);
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(3))
            0: return '1;
            1: return '0;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        exp_t ne;
        if (mon_en && !rst) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    expire("sb_extra_result");
                end else begin
                    e = q.pop_front();
                    check("sb_sum", {out_cout, out_sum}, {e.r.cout, e.r.sum});
`ifdef CLA_PIPE_FLAGS_EN
                    check("sb_flags", {out_ovf, out_zero}, {e.r.ovf, e.r.zero});
`endif
                    if (lat_chk) check("sb_latency", cyc - e.t, ST);
                    n_del++;
                    if (n_del == 1) first_del = cyc;
                    last_del = cyc;
                end
            end
            if (in_valid && in_ready) begin
                ne.r = model(in_a, in_b, in_cin, in_sub);
                ne.t = cyc;
                q.push_back(ne);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
        bit acc;
        int guard;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = 1'b1;
        acc      = 1'b0;
        guard    = 0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
            if (!acc && guard > 200) begin
                expire("send_accept");
                break;
            end
        end
    endtask

    task automatic run_vec(input int i);
        int lat;
        send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("vec%0d_latency", i), lat, ST);
        check($sformatf("vec%0d_sum", i), out_sum, tbl[i].sum);
        check($sformatf("vec%0d_cout", i), out_cout, tbl[i].cout);
`ifdef CLA_PIPE_FLAGS_EN
        check($sformatf("vec%0d_ovf", i), out_ovf, tbl[i].ovf);
        check($sformatf("vec%0d_zero", i), out_zero, tbl[i].zero);
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int stale;

        //         a             b             cin   sub   sum           cout  ovf   zero
        tbl[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_sum", out_sum, 0);
        check("reset_out_cout", out_cout, 0);
`ifdef CLA_PIPE_FLAGS_EN
        check("reset_flags", {out_ovf, out_zero}, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) run_vec(i);

        // Eight back-to-back beats, consumer always ready.
        q.delete();
        n_del   = 0;
        mon_en  = 1'b1;
        lat_chk = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(32'h0001_1111 * i + 32'hFFFF, 32'h0F0F_0F0F ^ i,
                 i[0], (i % 3) == 0);
        end
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("burst_count", n_del, 8);
        check("burst_consecutive", last_del - first_del, 7);
        check("burst_queue_empty", q.size(), 0);

        // Stall with a full pipeline and a pending beat held at the input.
        n_del     = 0;
        lat_chk   = 1'b0;
        out_ready = 1'b0;
        send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        send(32'h00000010, 32'h00000020, 1'b0, 1'b0);
        in_a     = 32'h00000100;
        in_b     = 32'h00000001;
        in_cin   = 1'b0;
        in_sub   = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_held", {out_cout, out_sum}, 33'h1_0000_0000);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(32'h00000100, 32'h00000001, 1'b0, 1'b1);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("stall_count", n_del, 3);
        check("stall_queue_empty", q.size(), 0);

        // Asynchronous reset with two beats in flight.
        mon_en = 1'b0;
        q.delete();
        send(32'h00000011, 32'h00000022, 1'b0, 1'b0);
        send(32'h00000033, 32'h00000044, 1'b0, 1'b0);
        in_valid = 1'b0;
        check("prerst_out_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_sum", out_sum, 0);
        check("midrst_out_cout", out_cout, 0);
        @(negedge clk);
        rst = 1'b0;
        check("release_in_ready", in_ready, 1);
        stale = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        check("no_stale_result", stale, 0);
        run_vec(5);

        // Random traffic with random backpressure, checked in order.
        q.delete();
        n_del   = 0;
        mon_en  = 1'b1;
        lat_chk = 1'b0;
        done    = 1'b0;
        fork
            begin
                for (int i = 0; i < NR; i++) begin
                    while ($urandom_range(3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    send(pick(), pick(), 1'($urandom_range(1)),
                         1'($urandom_range(1)));
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(3) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1;
        check("random_count", n_del, NR);
        check("random_queue_empty", q.size(), 0);
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
